// File: rtl/rk4_lbe_dlk_pkg.sv
// Shared types and defaults for the RK4_LBE deadlock reporter.
package rk4_lbe_dlk_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StStall,
    StDeadlock
  } dlk_state_e;

  localparam int unsigned DLK_THRESHOLD_DEF = 1024;
  localparam int unsigned DLK_CNT_W_DEF     = 32;
  localparam int unsigned DLK_EPI_W_DEF     = 16;
  localparam int unsigned TS_W              = 64;

endpackage

// File: rtl/rk4_lbe_sat_counter.sv
// Saturating up-counter with load-to-one and clear.
// Priority: clr over load1 over inc. Holds at all-ones once reached.
module rk4_lbe_sat_counter #(
  parameter int unsigned Width = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load1,
  input  logic             inc,
  input  logic             clr,
  output logic [Width-1:0] count
);

  logic [Width-1:0] count_q, count_d;

  // Next count: clear, restart at one, or saturating increment.
  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (load1) begin
      count_d = Width'(1);
    end else if (inc && (count_q != '1)) begin
      count_d = count_q + Width'(1);
    end
  end

  // Count register, synchronous active-high reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/rk4_lbe_deadlock_reporter.sv
// Deadlock reporter: qualifies the deadlock monitor's block output by
// persistence. A stall held THRESHOLD consecutive busy cycles raises a sticky
// deadlock flag and a one-cycle irq. Optional capture-time timestamp is
// enabled by defining RK4_LBE_DEADLOCK_TIMESTAMP_EN; otherwise timestamp is 0.
module rk4_lbe_deadlock_reporter
  import rk4_lbe_dlk_pkg::*;
#(
  parameter int unsigned THRESHOLD = DLK_THRESHOLD_DEF,
  parameter int unsigned CNT_W     = DLK_CNT_W_DEF,
  parameter int unsigned EPI_W     = DLK_EPI_W_DEF
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             block_in,
  input  logic             idle_in,
  input  logic             clear,
  output logic             deadlock,
  output logic             irq,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [EPI_W-1:0] transient_count,
  output logic [TS_W-1:0]  timestamp
);

  localparam logic [CNT_W-1:0] ThreshM1 = CNT_W'(THRESHOLD - 1);

  dlk_state_e state_q, state_d;
  logic       deadlock_q, deadlock_d;
  logic       irq_q, irq_d;
  logic       q;
  logic       stall_load1, stall_inc;
  logic       epi_inc;
  logic       declare;

  // Block only counts while the kernel is busy.
  assign q = block_in & ~idle_in;

  // Next-state and counter controls; clear overrides every transition.
  always_comb begin
    state_d     = state_q;
    deadlock_d  = deadlock_q;
    irq_d       = 1'b0;
    stall_load1 = 1'b0;
    stall_inc   = 1'b0;
    epi_inc     = 1'b0;
    declare     = 1'b0;
    if (clear) begin
      state_d    = StIdle;
      deadlock_d = 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (q) begin
            state_d     = StStall;
            stall_load1 = 1'b1;
          end
        end
        StStall: begin
          if (q) begin
            stall_inc = 1'b1;
            if (stall_cycles == ThreshM1) begin
              state_d    = StDeadlock;
              deadlock_d = 1'b1;
              irq_d      = 1'b1;
              declare    = 1'b1;
            end
          end else begin
            state_d = StIdle;
            epi_inc = 1'b1;
          end
        end
        StDeadlock: begin
          stall_inc = q;
        end
        default: begin
          state_d = StIdle;
        end
      endcase
    end
  end

  // FSM state and flag registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= StIdle;
      deadlock_q <= 1'b0;
      irq_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      deadlock_q <= deadlock_d;
      irq_q      <= irq_d;
    end
  end

  rk4_lbe_sat_counter #(
    .Width (CNT_W)
  ) u_stall_cnt (
    .clock (clock),
    .reset (reset),
    .load1 (stall_load1),
    .inc   (stall_inc),
    .clr   (clear),
    .count (stall_cycles)
  );

  rk4_lbe_sat_counter #(
    .Width (EPI_W)
  ) u_epi_cnt (
    .clock (clock),
    .reset (reset),
    .load1 (1'b0),
    .inc   (epi_inc),
    .clr   (clear),
    .count (transient_count)
  );

`ifdef RK4_LBE_DEADLOCK_TIMESTAMP_EN
  logic [TS_W-1:0] cyc_q;
  logic [TS_W-1:0] ts_q, ts_d;

  // Free-running cycle counter; value k during the k-th cycle after reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      cyc_q <= '0;
    end else begin
      cyc_q <= cyc_q + TS_W'(1);
    end
  end

  // Capture the declaring cycle's count; cleared by software clear.
  always_comb begin
    ts_d = ts_q;
    if (clear) begin
      ts_d = '0;
    end else if (declare) begin
      ts_d = cyc_q;
    end
  end

  // Timestamp register.
  always_ff @(posedge clock) begin
    if (reset) begin
      ts_q <= '0;
    end else begin
      ts_q <= ts_d;
    end
  end

  assign timestamp = ts_q;
`else
  logic unused_declare;
  assign unused_declare = declare;
  assign timestamp      = '0;
`endif

  assign deadlock = deadlock_q;
  assign irq      = irq_q;

endmodule

// File: tb/tb_rk4_lbe_deadlock_reporter.sv
// Self-checking bench for rk4_lbe_deadlock_reporter.
// Instance a: THRESHOLD=8. Instance b: THRESHOLD=3, CNT_W=4 (saturation).
module tb_rk4_lbe_deadlock_reporter;

`ifdef RK4_LBE_DEADLOCK_TIMESTAMP_EN
  localparam bit TsEn = 1'b1;
`else
  localparam bit TsEn = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        block_in = 1'b0;
  logic        idle_in = 1'b0;
  logic        clear = 1'b0;

  logic        a_dl, a_irq;
  logic [31:0] a_st;
  logic [15:0] a_tc;
  logic [63:0] a_ts;

  logic        b_dl, b_irq;
  logic [3:0]  b_st;
  logic [3:0]  b_tc;
  logic [63:0] b_ts;

  int unsigned n_chk  = 0;
  int unsigned n_pass = 0;

  always #5 clock = ~clock;

  rk4_lbe_deadlock_reporter #(
    .THRESHOLD (8),
    .CNT_W     (32),
    .EPI_W     (16)
  ) dut_a (
    .clock           (clock),
    .reset           (reset),
    .block_in        (block_in),
    .idle_in         (idle_in),
    .clear           (clear),
    .deadlock        (a_dl),
    .irq             (a_irq),
    .stall_cycles    (a_st),
    .transient_count (a_tc),
    .timestamp       (a_ts)
  );

  rk4_lbe_deadlock_reporter #(
    .THRESHOLD (3),
    .CNT_W     (4),
    .EPI_W     (4)
  ) dut_b (
    .clock           (clock),
    .reset           (reset),
    .block_in        (block_in),
    .idle_in         (idle_in),
    .clear           (clear),
    .deadlock        (b_dl),
    .irq             (b_irq),
    .stall_cycles    (b_st),
    .transient_count (b_tc),
    .timestamp       (b_ts)
  );

  typedef struct {
    logic        b;
    logic        i;
    logic        c;
    logic        dl;
    logic        irq;
    int unsigned st;
    int unsigned tc;
  } vec_t;

  vec_t vecs[22];

  function automatic vec_t mk(logic b, logic i, logic c, logic dl, logic irq,
                              int unsigned st, int unsigned tc);
    vec_t v;
    v.b = b; v.i = i; v.c = c; v.dl = dl; v.irq = irq; v.st = st; v.tc = tc;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs, then sample just after the edge ending it.
  task automatic step(input logic b, input logic i, input logic c);
    block_in = b;
    idle_in  = i;
    clear    = c;
    @(posedge clock);
    #1;
  endtask

  task automatic chk_a(input string name, input logic dl, input logic irq,
                       input int unsigned st, input int unsigned tc);
    chk({name, ".deadlock"}, 64'(a_dl), 64'(dl));
    chk({name, ".irq"}, 64'(a_irq), 64'(irq));
    chk({name, ".stall"}, 64'(a_st), 64'(st));
    chk({name, ".transient"}, 64'(a_tc), 64'(tc));
  endtask

  initial begin
    // Table for instance a, starting from a cleared IDLE state.
    vecs[0]  = mk(0, 0, 0, 0, 0, 0, 0);
    vecs[1]  = mk(1, 0, 0, 0, 0, 1, 0);
    vecs[2]  = mk(1, 0, 0, 0, 0, 2, 0);
    vecs[3]  = mk(1, 0, 0, 0, 0, 3, 0);
    vecs[4]  = mk(1, 0, 0, 0, 0, 4, 0);
    vecs[5]  = mk(1, 0, 0, 0, 0, 5, 0);
    vecs[6]  = mk(0, 0, 0, 0, 0, 5, 1);
    vecs[7]  = mk(1, 0, 0, 0, 0, 1, 1);
    vecs[8]  = mk(1, 0, 0, 0, 0, 2, 1);
    vecs[9]  = mk(1, 0, 0, 0, 0, 3, 1);
    vecs[10] = mk(1, 0, 0, 0, 0, 4, 1);
    vecs[11] = mk(1, 0, 0, 0, 0, 5, 1);
    vecs[12] = mk(1, 0, 0, 0, 0, 6, 1);
    vecs[13] = mk(1, 0, 0, 0, 0, 7, 1);
    vecs[14] = mk(1, 0, 0, 1, 1, 8, 1);
    vecs[15] = mk(1, 0, 0, 1, 0, 9, 1);
    vecs[16] = mk(0, 0, 0, 1, 0, 9, 1);
    vecs[17] = mk(1, 0, 1, 0, 0, 0, 0);
    vecs[18] = mk(1, 1, 0, 0, 0, 0, 0);
    vecs[19] = mk(1, 0, 0, 0, 0, 1, 0);
    vecs[20] = mk(0, 0, 0, 0, 0, 1, 1);
    vecs[21] = mk(0, 0, 1, 0, 0, 0, 0);

    // Reset; deasserting just after an edge makes the current cycle cycle 0.
    reset = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
    chk_a("reset", 1'b0, 1'b0, 0, 0);
    chk("reset.timestamp", a_ts, 64'd0);

    // Stall from cycle 10 for 8 cycles: declared in cycle 18, ts = 17.
    for (int k = 0; k < 10; k++) step(1'b0, 1'b0, 1'b0);
    block_in = 1'b1;
    #2;
    chk("no_comb_path.stall", 64'(a_st), 64'd0);
    for (int k = 0; k < 8; k++) step(1'b1, 1'b0, 1'b0);
    chk_a("declare_c18", 1'b1, 1'b1, 8, 0);
    chk("declare_c18.timestamp", a_ts, TsEn ? 64'd17 : 64'd0);
    step(1'b0, 1'b0, 1'b0);
    chk_a("after_c19", 1'b1, 1'b0, 8, 0);
    chk("after_c19.timestamp", a_ts, TsEn ? 64'd17 : 64'd0);
    step(1'b0, 1'b0, 1'b1);
    chk_a("clear_dl", 1'b0, 1'b0, 0, 0);
    chk("clear_dl.timestamp", a_ts, 64'd0);

    // Table-driven sequence.
    for (int k = 0; k < 22; k++) begin
      step(vecs[k].b, vecs[k].i, vecs[k].c);
      chk_a($sformatf("vec%0d", k), vecs[k].dl, vecs[k].irq, vecs[k].st, vecs[k].tc);
    end

    // Clear on the cycle the count would reach THRESHOLD: no irq, restart.
    for (int k = 0; k < 7; k++) step(1'b1, 1'b0, 1'b0);
    chk_a("pre_thresh", 1'b0, 1'b0, 7, 0);
    step(1'b1, 1'b0, 1'b1);
    chk_a("clear_at_thresh", 1'b0, 1'b0, 0, 0);
    step(1'b1, 1'b0, 1'b0);
    chk_a("restart_after_clear", 1'b0, 1'b0, 1, 0);
    step(1'b0, 1'b0, 1'b1);
    chk_a("clear2", 1'b0, 1'b0, 0, 0);

    // Idle masks block entirely.
    for (int k = 0; k < 20; k++) begin
      step(1'b1, 1'b1, 1'b0);
      chk($sformatf("idle_mask%0d", k), {a_dl, a_irq, a_st, a_tc, 14'd0}, 64'd0);
    end

    // Reset while in DEADLOCK; cycle counter restarts from 0.
    for (int k = 0; k < 8; k++) step(1'b1, 1'b0, 1'b0);
    chk_a("pre_reset_dl", 1'b1, 1'b1, 8, 0);
    step(1'b1, 1'b0, 1'b0);
    chk_a("pre_reset_dl2", 1'b1, 1'b0, 9, 0);
    reset = 1'b1;
    step(1'b1, 1'b0, 1'b0);
    reset = 1'b0;
    chk_a("reset_in_dl", 1'b0, 1'b0, 0, 0);
    chk("reset_in_dl.timestamp", a_ts, 64'd0);
    for (int k = 0; k < 8; k++) step(1'b1, 1'b0, 1'b0);
    chk_a("redeclare", 1'b1, 1'b1, 8, 0);
    chk("redeclare.timestamp", a_ts, TsEn ? 64'd7 : 64'd0);

    // Instance b: THRESHOLD=3, 4-bit stall counter saturates at 15.
    reset = 1'b1;
    step(1'b0, 1'b0, 1'b0);
    reset = 1'b0;
    chk("b_reset.timestamp", b_ts, 64'd0);
    chk("b_reset.stall", 64'(b_st), 64'd0);
    for (int k = 0; k < 40; k++) begin
      step(1'b1, 1'b0, 1'b0);
      if (k == 2) begin
        chk("b_declare.deadlock", 64'(b_dl), 64'd1);
        chk("b_declare.irq", 64'(b_irq), 64'd1);
        chk("b_declare.stall", 64'(b_st), 64'd3);
      end else if (k == 3) begin
        chk("b_after.irq", 64'(b_irq), 64'd0);
        chk("b_after.stall", 64'(b_st), 64'd4);
      end
    end
    chk("b_sat.stall", 64'(b_st), 64'd15);
    chk("b_sat.deadlock", 64'(b_dl), 64'd1);
    chk("b_sat.transient", 64'(b_tc), 64'd0);
    step(1'b0, 1'b0, 1'b0);
    chk("b_hold.deadlock", 64'(b_dl), 64'd1);
    chk("b_hold.stall", 64'(b_st), 64'd15);
    step(1'b0, 1'b0, 1'b1);
    chk("b_clear.deadlock", 64'(b_dl), 64'd0);
    chk("b_clear.stall", 64'(b_st), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
